// File: rtl/if_fetch_stage_if.sv
// Bundle of the fetch stage's three channels: instruction-memory request/response,
// redirect from branch resolution, and the instruction handoff to decode.
interface if_fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output if_valid, if_instr, if_pc, if_pc_plus4,
    input  id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  if_valid, if_instr, if_pc, if_pc_plus4,
    output id_ready
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: owns the PC, streams word fetches to imem, buffers the
// in-order responses and hands {instr, pc} to decode; redirects flush and restart.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  if_fetch_stage_if.master bus
);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      out_instr_q, out_instr_d;
  logic [31:0]      out_pc_q, out_pc_d;
  logic [31:0]      out_pc_plus4_q, out_pc_plus4_d;

  logic [31:0] mem_instr_q [FIFO_DEPTH];
  logic [31:0] mem_pc_q    [FIFO_DEPTH];

  logic [CNT_W:0]   inflight;
  logic [CNT_W-1:0] count_after_pop;
  logic             req_valid;
  logic             req_fire;
  logic             rsp_fire;
  logic             push;
  logic             pop;

  // Buffered plus in-flight fetches never exceed the FIFO, so a push can never overflow.
  assign inflight  = {1'b0, outstanding_q} + {1'b0, count_q};
  assign req_valid = !rst && !bus.redirect_valid && (inflight < DEPTH_SUM);
  assign req_fire  = req_valid && bus.imem_req_ready;

  // A response with nothing outstanding belongs to a pre-reset request and is ignored.
  assign rsp_fire = bus.imem_rsp_valid && (outstanding_q != '0);
  assign push     = rsp_fire && !bus.redirect_valid && (discard_q == '0);
  assign pop      = (count_q != '0) && bus.id_ready && !bus.redirect_valid;

  assign count_after_pop = count_q - CNT_W'(pop);

  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    rsp_pc_d       = rsp_pc_q;
    outstanding_d  = outstanding_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    discard_d      = discard_q;
    count_d        = count_q;
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    out_instr_d    = out_instr_q;
    out_pc_d       = out_pc_q;
    out_pc_plus4_d = out_pc_plus4_q;

    if (bus.redirect_valid) begin
      fetch_pc_d = bus.redirect_pc & ~32'd3;
      rsp_pc_d   = bus.redirect_pc & ~32'd3;
      discard_d  = outstanding_q - CNT_W'(rsp_fire);
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (rsp_fire && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);

      // Output registers mirror the next head; when the FIFO drains they keep their last value.
      if (count_d != '0) begin
        if (count_after_pop == '0) begin
          out_instr_d = bus.imem_rsp_data;
          out_pc_d    = rsp_pc_q;
        end else begin
          out_instr_d = mem_instr_q[rd_ptr_d];
          out_pc_d    = mem_pc_q[rd_ptr_d];
        end
        out_pc_plus4_d = out_pc_d + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q     <= RESET_PC;
      rsp_pc_q       <= RESET_PC;
      outstanding_q  <= '0;
      discard_q      <= '0;
      count_q        <= '0;
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      out_instr_q    <= NOP;
      out_pc_q       <= 32'd0;
      out_pc_plus4_q <= 32'd4;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      rsp_pc_q       <= rsp_pc_d;
      outstanding_q  <= outstanding_d;
      discard_q      <= discard_d;
      count_q        <= count_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      out_instr_q    <= out_instr_d;
      out_pc_q       <= out_pc_d;
      out_pc_plus4_q <= out_pc_plus4_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= bus.imem_rsp_data;
      mem_pc_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = (count_q != '0);
  assign bus.if_instr       = out_instr_q;
  assign bus.if_pc          = out_pc_q;
  assign bus.if_pc_plus4    = out_pc_plus4_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed phases push expected PCs, a memory
// model answers fetches, and a decode-side monitor pops and compares each instruction.
module tb_if_fetch_stage;
  localparam logic [31:0] RESET_PC   = 32'hFFFF_FFF8;
  localparam int          FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;

  if_fetch_stage_if bus();

  if_fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  logic        allow_ready = 1'b0;
  logic [31:0] sb[$];
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] hs_addrs[$];
  int          hs_count = 0;
  int          cons_count = 0;
  int          first_cons_cyc = 0;
  int          last_cons_cyc = 0;
  logic [31:0] mon_pc;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  function automatic logic [31:0] hsAddr(input int i);
    if (hs_addrs.size() > i) return hs_addrs[i];
    return 32'hxxxx_xxxx;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] start_pc, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start_pc + 32'(4 * i));
    allow_ready = 1'b1;
  endtask

  task automatic waitDrain(input string name, input int max_cycles);
    int n = 0;
    while (sb.size() != 0 && n < max_cycles) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s: got %0d instrs still pending, expected 0", name, sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic holdAndReleaseReset();
    sb.delete();
    allow_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    hs_addrs.delete();
    hs_count = 0;
    cons_count = 0;
    rst = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1;
    holdAndReleaseReset();
  endtask

  // Instruction memory: in-order responses mem_lat cycles after acceptance.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq_addr.delete();
        mq_due.delete();
        cyc++;
        #1;
        bus.imem_rsp_valid = 1'b0;
      end else begin
        if (bus.imem_rsp_valid && mq_addr.size() > 0) begin
          void'(mq_addr.pop_front());
          void'(mq_due.pop_front());
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          mq_addr.push_back(bus.imem_req_addr);
          mq_due.push_back(cyc + mem_lat);
          hs_addrs.push_back(bus.imem_req_addr);
          hs_count++;
        end
        cyc++;
        #1;
        if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = memWord(mq_addr[0]);
        end else begin
          bus.imem_rsp_valid = 1'b0;
        end
      end
    end
  end

  // Decode accepts only while the scoreboard still expects instructions.
  initial begin
    bus.id_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      bus.id_ready = allow_ready && (sb.size() > 0) && !rst;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.if_valid && bus.id_ready && !bus.redirect_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("[TB] FAIL unexpected_instr: got pc %h, expected none", bus.if_pc);
        end else begin
          mon_pc = sb.pop_front();
          checkOutput("if_pc", bus.if_pc, mon_pc);
          checkOutput("if_instr", bus.if_instr, memWord(mon_pc));
          checkOutput("if_pc_plus4", bus.if_pc_plus4, mon_pc + 32'd4);
        end
        if (cons_count == 0) first_cons_cyc = cyc;
        last_cons_cyc = cyc;
        cons_count++;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int acc;
    int val;
    int base;

    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_req_valid", bus.imem_req_valid, 32'd0);
    checkOutput("rst_if_valid", bus.if_valid, 32'd0);
    checkOutput("rst_if_instr", bus.if_instr, 32'h0000_0013);
    checkOutput("rst_if_pc", bus.if_pc, 32'd0);
    checkOutput("rst_if_pc_plus4", bus.if_pc_plus4, 32'd4);
    @(posedge clk); #1;
    rst = 1'b0;

    // Free run across the 2^32 wrap with a 1-cycle memory.
    applyStimulus(RESET_PC, 12);
    acc = -100;
    val = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        acc = cyc;
        break;
      end
    end
    for (int i = 0; i < 20; i++) begin
      if (bus.if_valid) begin
        val = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput("p1_first_valid_latency", 32'(val - acc), 32'd2);
    waitDrain("p1_drain", 100);
    checkOutput("p1_first_addr", hsAddr(0), 32'hFFFF_FFF8);
    checkOutput("p1_wrap_addr", hsAddr(2), 32'h0000_0000);
    checkOutput("p1_consumed", 32'(cons_count), 32'd12);
    checkOutput("p1_throughput", 32'(last_cons_cyc - first_cons_cyc), 32'd11);

    // Decode stalled: FIFO fills to depth and requests stop.
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("p2_req_valid_stalled", bus.imem_req_valid, 32'd0);
    checkOutput("p2_if_valid_stalled", bus.if_valid, 32'd1);
    checkOutput("p2_total_requests", 32'(hs_count), 32'd16);
    checkOutput("p2_last_addr", hsAddr(15), 32'h0000_0034);
    @(posedge clk); #1;
    applyStimulus(32'h0000_0028, 8);
    waitDrain("p2_drain", 100);

    // Redirect with two fetches in flight on a 3-cycle memory.
    mem_lat = 3;
    doReset();
    n = 0;
    while (hs_count < 2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("p3_inflight", 32'(hs_count), 32'd2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    checkOutput("p3_no_req_in_redirect", bus.imem_req_valid, 32'd0);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    applyStimulus(32'h0000_0100, 4);
    waitDrain("p3_drain", 100);
    checkOutput("p3_target_addr", hsAddr(2), 32'h0000_0100);

    // Memory not ready: address and request count hold.
    mem_lat = 1;
    doReset();
    applyStimulus(RESET_PC, 8);
    n = 0;
    while (hs_count < 3 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("p4_req_valid_held", bus.imem_req_valid, 32'd1);
      checkOutput("p4_addr_held", bus.imem_req_addr, 32'h0000_0004);
    end
    @(posedge clk); #1;
    checkOutput("p4_no_accept", 32'(hs_count), 32'd3);
    bus.imem_req_ready = 1'b1;
    waitDrain("p4_drain", 100);
    checkOutput("p4_resume_addr", hsAddr(3), 32'h0000_0004);

    // Back-to-back redirects: the second target wins.
    base = hs_count;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    checkOutput("p5_no_req_first", bus.imem_req_valid, 32'd0);
    @(posedge clk); #1;
    bus.redirect_pc = 32'h0000_0300;
    @(negedge clk);
    checkOutput("p5_no_req_second", bus.imem_req_valid, 32'd0);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b0;
    applyStimulus(32'h0000_0300, 4);
    waitDrain("p5_drain", 100);
    checkOutput("p5_target_addr", hsAddr(base), 32'h0000_0300);

    // Reset asserted mid-stream takes effect immediately, then fetch restarts at RESET_PC.
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("p6_if_valid_before", bus.if_valid, 32'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkOutput("p6_rst_if_valid", bus.if_valid, 32'd0);
    checkOutput("p6_rst_req_valid", bus.imem_req_valid, 32'd0);
    checkOutput("p6_rst_if_instr", bus.if_instr, 32'h0000_0013);
    checkOutput("p6_rst_if_pc", bus.if_pc, 32'd0);
    checkOutput("p6_rst_if_pc_plus4", bus.if_pc_plus4, 32'd4);
    @(posedge clk); #1;
    holdAndReleaseReset();
    applyStimulus(RESET_PC, 4);
    waitDrain("p6_drain", 100);
    checkOutput("p6_restart_addr", hsAddr(0), RESET_PC);
    checkOutput("p6_wrap_addr", hsAddr(2), 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Owns the PC and issues word-aligned requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions in a small FIFO and presents them with their PC to decode under a valid/ready handshake.
- Handles redirects from branch/jump resolution: flushes buffered and in-flight fetches and restarts at the target.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 4, response buffer entries; power of two, ≥2; also caps in-flight plus buffered fetches.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous and active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  fetch address, bits [1:0] always 0.
- imem_rsp_valid  input  1  instruction word returned; in order, ≥1 cycle after acceptance; no backpressure.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  taken branch/jal/jalr; flush and refetch.
- redirect_pc  input  32  redirect target; bits [1:0] forced to 0.
- if_valid  output  1  if_instr/if_pc valid for decode.
- id_ready  input  1  decode consumes this cycle; low = stall.
- if_instr  output  32  instruction; opcode/funct3/funct7 feed the decoder.
- if_pc  output  32  PC of if_instr.
- if_pc_plus4  output  32  if_pc + 4, wrapping mod 2^32.

Behaviour:
- Reset, asynchronous and immediate:
  - fetch_pc = RESET_PC, rsp_pc = RESET_PC.
  - outstanding, discard and FIFO count = 0.
  - imem_req_valid = 0, if_valid = 0.
  - if_instr = 32'h0000_0013 (NOP); if_pc = 0; if_pc_plus4 = 4.
  - Reset mid-operation drops everything in flight. Responses arriving after reset release are ignored if outstanding = 0.
- Request issue:
  - imem_req_valid = !redirect_valid && (outstanding + count < FIFO_DEPTH), using registered counts only.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 and outstanding++.
  - The address stays stable while valid && !ready.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If discard > 0 or redirect_valid is high: the response is dropped and discard decrements when > 0.
  - Otherwise {data, rsp_pc} is pushed and rsp_pc += 4.
  - Push never overflows, guaranteed by the issue rule.
- Output:
  - FIFO head registered and visible the cycle after push.
  - if_valid = count != 0.
  - Pop when if_valid && id_ready && !redirect_valid.
  - Push and pop in the same cycle: count unchanged.
  - If empty, outputs hold their last values with if_valid = 0.
- Redirect (cycle N):
  - FIFO cleared.
  - fetch_pc and rsp_pc set to redirect_pc & ~3.
  - discard = outstanding minus any response in cycle N.
  - No request in cycle N. Pop in N has no effect; decode discards the if_valid=1 presented in N.
  - First request to the target in N+1. With 1-cycle memory: response in N+2, if_valid in N+3.
  - Back-to-back redirects: the last one wins; discard is recomputed each time.
- Throughput:
  - With 1-cycle memory and id_ready=1, one instruction per cycle in steady state.
  - id_ready=0 fills FIFO to FIFO_DEPTH and then requests stop.
- Arithmetic: PC increments wrap at 2^32 (FFFF_FFFC + 4 = 0).

Test Plan:
- Reset then free run, 1-cycle memory returning addr-derived words, id_ready=1 → requests 0x0,0x4,0x8…; first if_valid 2 cycles after first accept; then one instr/cycle with if_pc matching the word; if_pc_plus4 = if_pc+4.
- Hold id_ready=0 for 10 cycles → exactly 4 entries buffered and req_valid low; release → 4 buffered instrs in order, fetch resumes with no PC gap or duplicate.
- Redirect to 0x0000_0103 with 2 fetches in flight on a 3-cycle memory → both responses dropped; next request addr 0x100; first if_pc = 0x100.
- imem_req_ready low 5 cycles with req_valid high → addr held constant; outstanding unchanged.
- Redirects in consecutive cycles to 0x200 then 0x300 → nothing from 0x200 is ever presented; first if_pc = 0x300.
- RESET_PC = 0xFFFF_FFF8, free run → fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc_plus4 of FFFF_FFFC = 0; rst asserted mid-stream → if_valid low immediately; restart at RESET_PC.
